// File: rtl/jtframe_romarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romarb_pkg
//  Description : Shared types and constants for the four-slot SDRAM read
//                arbiter (FSM state encoding, slot count, grant index type).
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_romarb_pkg;

    localparam int SLOTS = 4;

    // Arbiter transaction states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    // Index of a granted slot
    typedef logic [1:0] slot_idx_t;

    // One-hot completion vector for a slot index
    function automatic logic [SLOTS-1:0] slot_onehot(input slot_idx_t idx);
        logic [SLOTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_romarb_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romarb_if
//  Description : Slot-side and SDRAM-side bus of the ROM read arbiter.
//                master : arbiter view (it masters the SDRAM read port)
//                slave  : environment view (slots + SDRAM controller)
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_romarb_if
    import jtframe_romarb_pkg::*;
#(
    parameter int AW = 22
) ();

    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [31:0]         dout;

    modport master (
        input  slot_req,
        input  slot_addr,
        input  sdram_ack,
        input  data_rdy,
        input  data_read,
        output sdram_req,
        output sdram_addr,
        output slot_ok,
        output dout
    );

    modport slave (
        output slot_req,
        output slot_addr,
        output sdram_ack,
        output data_rdy,
        output data_read,
        input  sdram_req,
        input  sdram_addr,
        input  slot_ok,
        input  dout
    );

endinterface
`default_nettype wire

// File: rtl/jtframe_romarb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romarb_pick
//  Description : Combinational slot picker. Fixed priority (slot 0 highest)
//                by default; round-robin starting at the pointer when
//                JTFRAME_ROMARB_RR_EN is defined.
//  Config      : JTFRAME_ROMARB_RR_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_romarb_pick
    import jtframe_romarb_pkg::*;
(
    input  logic [SLOTS-1:0] req,
`ifdef JTFRAME_ROMARB_RR_EN
    input  slot_idx_t        ptr,
`endif
    output slot_idx_t        gnt,
    output logic             valid
);

`ifdef JTFRAME_ROMARB_RR_EN
    // Scan from the farthest slot back to ptr so the first requester at or after ptr wins
    always_comb begin
        slot_idx_t idx;
        idx   = '0;
        gnt   = '0;
        valid = |req;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            idx = ptr + slot_idx_t'(i);
            if (req[idx]) begin
                gnt = idx;
            end
        end
    end
`else
    // Scan from lowest priority upward so slot 0 overrides everything
    always_comb begin
        gnt   = '0;
        valid = |req;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt = slot_idx_t'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/jtframe_romarb.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romarb
//  Description : Four-slot SDRAM read arbiter. Serialises slot read requests
//                into single SDRAM reads and returns the word with a one-cycle
//                per-slot completion strobe.
//  Config      : JTFRAME_ROMARB_RR_EN (round-robin instead of fixed priority)
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_romarb
    import jtframe_romarb_pkg::*;
#(
    parameter int            AW      = 22,
    parameter logic [AW-1:0] OFFSET0 = '0,
    parameter logic [AW-1:0] OFFSET1 = '0,
    parameter logic [AW-1:0] OFFSET2 = '0,
    parameter logic [AW-1:0] OFFSET3 = '0
) (
    input  logic             rst,
    input  logic             clk,
    jtframe_romarb_if.master bus
);

    localparam logic [AW-1:0] C_OFFSET [SLOTS] = '{OFFSET0, OFFSET1, OFFSET2, OFFSET3};

    state_t           state_q,      state_d;
    slot_idx_t        gnt_q,        gnt_d;
    logic             sdram_req_q,  sdram_req_d;
    logic [AW-1:0]    sdram_addr_q, sdram_addr_d;
    logic [SLOTS-1:0] slot_ok_q,    slot_ok_d;
    logic [31:0]      dout_q,       dout_d;
`ifdef JTFRAME_ROMARB_RR_EN
    slot_idx_t        ptr_q,        ptr_d;
`endif

    logic [AW-1:0]    w_slot_addr [SLOTS];
    logic [AW-1:0]    w_sel_addr;
    slot_idx_t        w_pick;
    logic             w_pick_valid;

    // Unpack the flat slot address bus into one word per slot
    generate
        for (genvar n = 0; n < SLOTS; n++) begin : g_slot
            assign w_slot_addr[n] = bus.slot_addr[n*AW +: AW];
        end
    endgenerate

    jtframe_romarb_pick u_pick (
        .req   (bus.slot_req),
`ifdef JTFRAME_ROMARB_RR_EN
        .ptr   (ptr_q),
`endif
        .gnt   (w_pick),
        .valid (w_pick_valid)
    );

    // Base offset plus slot address; the carry out of AW bits is dropped
    always_comb begin
        w_sel_addr = C_OFFSET[w_pick] + w_slot_addr[w_pick];
    end

    // Next-state and output computation for the read transaction FSM
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        slot_ok_d    = '0;
        dout_d       = dout_q;
`ifdef JTFRAME_ROMARB_RR_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Address and slot are captured here only; later input changes are ignored
                if (w_pick_valid) begin
                    gnt_d        = w_pick;
                    sdram_addr_d = w_sel_addr;
                    sdram_req_d  = 1'b1;
                    state_d      = WAIT_ACK;
`ifdef JTFRAME_ROMARB_RR_EN
                    ptr_d        = w_pick + 2'd1;
`endif
                end
            end
            WAIT_ACK: begin
                if (bus.sdram_ack) begin
                    sdram_req_d = 1'b0;
                    // Data may arrive together with the ack; finish straight away
                    if (bus.data_rdy) begin
                        dout_d    = bus.data_read;
                        slot_ok_d = slot_onehot(gnt_q);
                        state_d   = IDLE;
                    end else begin
                        state_d   = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (bus.data_rdy) begin
                    dout_d    = bus.data_read;
                    slot_ok_d = slot_onehot(gnt_q);
                    state_d   = IDLE;
                end
            end
            default: begin
                sdram_req_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any read without a completion strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            slot_ok_q    <= '0;
            dout_q       <= '0;
`ifdef JTFRAME_ROMARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            slot_ok_q    <= slot_ok_d;
            dout_q       <= dout_d;
`ifdef JTFRAME_ROMARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.slot_ok    = slot_ok_q;
    assign bus.dout       = dout_q;

endmodule
`default_nettype wire
